// File: rtl/bridge_req_arbiter_pkg.sv
// Shared bridge types: command word, parameter block and arbiter state encoding.
package bridge_req_arbiter_pkg;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned PARAM_W = 128;

  typedef logic [WORD_W-1:0]  bridge_word_t;
  typedef logic [PARAM_W-1:0] bridge_param_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RETIRE
  } arb_state_t;

endpackage

// File: rtl/bridge_req_arbiter_if.sv
// Requester-side and driver-side request channel bundle of the bridge arbiter.
interface bridge_req_arbiter_if
  import bridge_req_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4
);

  logic          [N_REQ-1:0] up_valid;
  bridge_word_t  [N_REQ-1:0] up_word;
  bridge_param_t [N_REQ-1:0] up_param;
  logic          [N_REQ-1:0] up_done;
  logic          [N_REQ-1:0] up_grant;
  bridge_word_t              up_progress;
  bridge_word_t              up_result;
  bridge_param_t             up_response;

  logic                      down_valid;
  bridge_word_t              down_word;
  bridge_param_t             down_param;
  bridge_word_t              down_progress;
  logic                      down_done;
  bridge_word_t              down_result;
  bridge_param_t             down_response;

  // Arbiter view
  modport master (
    input  up_valid, up_word, up_param,
    output up_done, up_grant, up_progress, up_result, up_response,
    output down_valid, down_word, down_param,
    input  down_progress, down_done, down_result, down_response
  );

  // Requesters plus driver view
  modport slave (
    output up_valid, up_word, up_param,
    input  up_done, up_grant, up_progress, up_result, up_response,
    input  down_valid, down_word, down_param,
    output down_progress, down_done, down_result, down_response
  );

endinterface

// File: rtl/bridge_req_arbiter_rr_pick.sv
// Round-robin winner search: first set request at or after ptr, wrapping modulo N_REQ.
module bridge_rr_pick
  import bridge_req_arbiter_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found_c,
  output logic [IDX_W-1:0] idx_c
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    cand    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((32'(ptr) + k) % N_REQ);
      if (!found_c && req[cand]) begin
        found_c = 1'b1;
        idx_c   = cand;
      end
    end
  end

endmodule

// File: rtl/bridge_req_arbiter.sv
// Round-robin sharing of the bridge driver request channel; one command in flight,
// completion routed back to the granted requester only.
module bridge_req_arbiter
  import bridge_req_arbiter_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  bridge_req_arbiter_if.master bus,
  output logic                 busy
);

  arb_state_t       state, state_next;
  logic             found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] grant_idx, grant_idx_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;

  logic [N_REQ-1:0] up_done_q, up_done_nxt;
  logic [N_REQ-1:0] up_grant_q, up_grant_nxt;
  bridge_word_t     up_progress_q, up_progress_nxt;
  bridge_word_t     up_result_q, up_result_nxt;
  bridge_param_t    up_response_q, up_response_nxt;
  logic             down_valid_q, down_valid_nxt;
  bridge_word_t     down_word_q, down_word_nxt;
  bridge_param_t    down_param_q, down_param_nxt;
  logic             busy_nxt;

  bridge_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (bus.up_valid),
    .ptr    (rr_ptr),
    .found_c(found),
    .idx_c  (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (found) state_next = ST_ISSUE;
      ST_ISSUE:  state_next = ST_WAIT;
      ST_WAIT:   if (bus.down_done) state_next = ST_RETIRE;
      ST_RETIRE: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from next-state so they line up with the state they belong to
  always_comb begin
    grant_idx_nxt   = grant_idx;
    rr_ptr_nxt      = rr_ptr;
    up_done_nxt     = '0;
    up_progress_nxt = up_progress_q;
    up_result_nxt   = up_result_q;
    up_response_nxt = up_response_q;
    down_word_nxt   = down_word_q;
    down_param_nxt  = down_param_q;
    down_valid_nxt  = (state_next == ST_ISSUE);
    busy_nxt        = (state_next != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (found) begin
          grant_idx_nxt  = pick_idx;
          down_word_nxt  = bus.up_word[pick_idx];
          down_param_nxt = bus.up_param[pick_idx];
        end
      end
      ST_WAIT: begin
        up_progress_nxt = bus.down_progress;
        if (bus.down_done) begin
          up_result_nxt   = bus.down_result;
          up_response_nxt = bus.down_response;
          up_done_nxt     = N_REQ'(1) << grant_idx;
          rr_ptr_nxt      = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
      end
      ST_RETIRE: up_progress_nxt = '0;
      default: ;
    endcase
    up_grant_nxt = (state_next == ST_IDLE) ? '0 : N_REQ'(1) << grant_idx_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_idx     <= '0;
      rr_ptr        <= '0;
      up_done_q     <= '0;
      up_grant_q    <= '0;
      up_progress_q <= '0;
      up_result_q   <= '0;
      up_response_q <= '0;
      down_valid_q  <= 1'b0;
      down_word_q   <= '0;
      down_param_q  <= '0;
      busy          <= 1'b0;
    end else begin
      grant_idx     <= grant_idx_nxt;
      rr_ptr        <= rr_ptr_nxt;
      up_done_q     <= up_done_nxt;
      up_grant_q    <= up_grant_nxt;
      up_progress_q <= up_progress_nxt;
      up_result_q   <= up_result_nxt;
      up_response_q <= up_response_nxt;
      down_valid_q  <= down_valid_nxt;
      down_word_q   <= down_word_nxt;
      down_param_q  <= down_param_nxt;
      busy          <= busy_nxt;
    end
  end

  assign bus.up_done     = up_done_q;
  assign bus.up_grant    = up_grant_q;
  assign bus.up_progress = up_progress_q;
  assign bus.up_result   = up_result_q;
  assign bus.up_response = up_response_q;
  assign bus.down_valid  = down_valid_q;
  assign bus.down_word   = down_word_q;
  assign bus.down_param  = down_param_q;

endmodule

// File: tb/tb_bridge_req_arbiter.sv
// Directed bench for bridge_req_arbiter: transaction table plus abort/spurious-done sequences.
module tb_bridge_req_arbiter;
  import bridge_req_arbiter_pkg::*;

  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic reset;
  logic busy;

  bridge_req_arbiter_if #(.N_REQ(N)) bus ();

  bridge_req_arbiter #(.N_REQ(N)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int last_issue = -1;

  typedef struct {
    bit          rst;
    logic [3:0]  set;
    int          idx;
    logic [15:0] res;
    int          dly;
    bit          drop;
  } vec_t;

  vec_t vecs[14];

  function automatic bridge_word_t word_of(input int i);
    return 16'h0070 + 16'(i) * 16'h0010;
  endfunction

  function automatic bridge_param_t param_of(input int i);
    return {16{8'(8'hA3 + i)}};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    reset             = 1'b1;
    bus.up_valid      = '0;
    bus.down_done     = 1'b0;
    bus.down_progress = '0;
    bus.down_result   = '0;
    bus.down_response = '0;
    repeat (2) @(negedge clk);
    check("rst_down_valid", 128'(bus.down_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_grant", 128'(bus.up_grant), 128'(0));
    check("rst_done", 128'(bus.up_done), 128'(0));
    check("rst_progress", 128'(bus.up_progress), 128'(0));
    check("rst_down_word", 128'(bus.down_word), 128'(0));
    check("rst_down_param", bus.down_param, 128'(0));
    check("rst_result", 128'(bus.up_result), 128'(0));
    check("rst_response", bus.up_response, 128'(0));
    reset      = 1'b0;
    last_issue = -1;
  endtask

  // Starts at an IDLE negedge, ends at the IDLE negedge after RETIRE
  task automatic do_txn(input logic [3:0] set, input int idx, input logic [15:0] res,
                        input int dly, input bit drop);
    int          n;
    logic [15:0] prog_exp;
    n        = 0;
    prog_exp = '0;
    bus.up_valid = bus.up_valid | set;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.down_valid && n < 12);
    if (!bus.down_valid) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: no down_valid after %0d cycles, required within 1", n);
      return;
    end
    check("issue_latency", 128'(n), 128'(1));
    if (last_issue >= 0) begin
      checks++;
      if (cyc - last_issue < 5) begin
        errors++;
        $display("FAIL issue_spacing: got %0d cycles required at least 5", cyc - last_issue);
      end
    end
    last_issue = cyc;
    check("issue_word", 128'(bus.down_word), 128'(word_of(idx)));
    check("issue_param", bus.down_param, param_of(idx));
    check("issue_grant", 128'(bus.up_grant), 128'(4'(1) << idx));
    check("issue_busy", 128'(busy), 128'(1));

    for (int k = 1; k <= dly; k++) begin
      @(negedge clk);
      check("wait_down_valid", 128'(bus.down_valid), 128'(0));
      check("wait_progress", 128'(bus.up_progress), 128'(prog_exp));
      prog_exp          = 16'(16'h0010 * k);
      bus.down_progress = prog_exp;
      if (k == dly) begin
        bus.down_done     = 1'b1;
        bus.down_result   = res;
        bus.down_response = {8{res}};
      end
    end

    @(negedge clk);
    bus.down_done     = 1'b0;
    bus.down_progress = '0;
    check("retire_done", 128'(bus.up_done), 128'(4'(1) << idx));
    check("retire_result", 128'(bus.up_result), 128'(res));
    check("retire_response", bus.up_response, {8{res}});
    check("retire_grant", 128'(bus.up_grant), 128'(4'(1) << idx));
    if (drop) bus.up_valid[idx] = 1'b0;

    @(negedge clk);
    check("idle_done", 128'(bus.up_done), 128'(0));
    check("idle_grant", 128'(bus.up_grant), 128'(0));
    check("idle_busy", 128'(busy), 128'(0));
    check("idle_progress", 128'(bus.up_progress), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // single request; contention 0..3; fairness 0/3; wrap-around of rr_ptr
    vecs[0]  = '{1'b1, 4'b0100, 2, 16'h0001, 2, 1'b1};
    vecs[1]  = '{1'b1, 4'b1111, 0, 16'h1111, 2, 1'b1};
    vecs[2]  = '{1'b0, 4'b0000, 1, 16'h2222, 3, 1'b1};
    vecs[3]  = '{1'b0, 4'b0000, 2, 16'h3333, 2, 1'b1};
    vecs[4]  = '{1'b0, 4'b0000, 3, 16'h4444, 2, 1'b1};
    vecs[5]  = '{1'b1, 4'b1001, 0, 16'h0A0A, 2, 1'b0};
    vecs[6]  = '{1'b0, 4'b0000, 3, 16'h0B0B, 2, 1'b0};
    vecs[7]  = '{1'b0, 4'b0000, 0, 16'h0C0C, 3, 1'b0};
    vecs[8]  = '{1'b0, 4'b0000, 3, 16'h0D0D, 2, 1'b0};
    vecs[9]  = '{1'b0, 4'b0000, 0, 16'h0E0E, 2, 1'b1};
    vecs[10] = '{1'b0, 4'b0000, 3, 16'h0F0F, 2, 1'b1};
    vecs[11] = '{1'b0, 4'b0011, 0, 16'h1234, 2, 1'b1};
    vecs[12] = '{1'b0, 4'b0000, 1, 16'h5678, 2, 1'b1};
    vecs[13] = '{1'b0, 4'b0001, 0, 16'h9ABC, 2, 1'b1};

    for (int i = 0; i < int'(N); i++) begin
      bus.up_word[i]  = word_of(i);
      bus.up_param[i] = param_of(i);
    end

    apply_reset();
    for (int v = 0; v < 14; v++) begin
      if (vecs[v].rst) apply_reset();
      do_txn(vecs[v].set, vecs[v].idx, vecs[v].res, vecs[v].dly, vecs[v].drop);
    end

    // Spurious down_done while idle must be ignored
    bus.down_done = 1'b1;
    @(negedge clk);
    bus.down_done = 1'b0;
    check("spur_done", 128'(bus.up_done), 128'(0));
    check("spur_busy", 128'(busy), 128'(0));
    @(negedge clk);
    check("spur_done_late", 128'(bus.up_done), 128'(0));
    check("spur_grant", 128'(bus.up_grant), 128'(0));
    do_txn(4'b0100, 2, 16'hBEEF, 2, 1'b1);

    // Reset in WAIT aborts with no up_done and rr_ptr back to 0
    bus.up_valid = 4'b1000;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.down_valid && n < 12);
    check("abort_issue", 128'(bus.down_valid), 128'(1));
    check("abort_grant", 128'(bus.up_grant), 128'(4'b1000));
    @(negedge clk);
    bus.down_done = 1'b1;
    reset         = 1'b1;
    bus.up_valid  = '0;
    @(negedge clk);
    check("abort_done", 128'(bus.up_done), 128'(0));
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_grant_clr", 128'(bus.up_grant), 128'(0));
    check("abort_down_word", 128'(bus.down_word), 128'(0));
    reset         = 1'b0;
    bus.down_done = 1'b0;
    last_issue    = -1;
    @(negedge clk);
    check("abort_done_after", 128'(bus.up_done), 128'(0));
    do_txn(4'b1001, 0, 16'hCAFE, 2, 1'b1);
    do_txn(4'b0000, 3, 16'hF00D, 2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
